// File: rtl/hpdcache_l15_req_arbiter_pkg.sv
// Shared helpers for the L1.5 request arbiter slice.
package hpdcache_l15_req_arbiter_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Single-step modulo: idx is never more than 2*n-2 at the call sites.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/hpdcache_l15_req_arbiter_rrarb.sv
// N-way round-robin arbiter: one-hot grant starting at the pointer, pointer
// moves past the winner when en is asserted.
module hpdcache_rrarb
  import hpdcache_l15_req_arbiter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] ptr;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      if (!found && req[rr_wrap(int'(ptr) + off, N)]) begin
        found   = 1'b1;
        gnt[rr_wrap(int'(ptr) + off, N)] = 1'b1;
        gnt_idx = PW'(rr_wrap(int'(ptr) + off, N));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= PW'(rr_wrap(int'(gnt_idx) + 1, N));
    end
  end

endmodule

// File: rtl/hpdcache_l15_req_arbiter.sv
// Round-robin N-to-1 arbiter into a one-entry output slot, with a per-ID
// routing table that steers responses back to the issuing port.
module hpdcache_l15_req_arbiter
  import hpdcache_l15_req_arbiter_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter type req_t        = logic,
  parameter type req_id_t     = logic,
  parameter type req_portid_t = logic
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [N-1:0] req_valid_i,
  output logic [N-1:0] req_ready_o,
  input  req_t        req_i    [N],
  input  req_id_t     req_id_i [N],
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output req_t        mem_req_o,
  output req_id_t     mem_req_id_o,
  input  logic        mem_resp_valid_i,
  input  logic        mem_resp_ready_i,
  input  req_id_t     mem_resp_id_i,
  output req_portid_t mem_resp_sel_o
);

  localparam int unsigned RT_DEPTH = 2 ** $bits(req_id_t);
  localparam int unsigned PW       = idx_width(N);

  logic [RT_DEPTH-1:0] rt_valid;
  req_portid_t         rt_port [RT_DEPTH];

  logic [N-1:0]  eligible;
  logic [N-1:0]  arb_req;
  logic [N-1:0]  gnt;
  logic [PW-1:0] gnt_idx;
  logic          slot_free;
  logic          grant;
  logic          resp_fire;
  req_id_t       gnt_id;

  // An ID already in flight blocks its requester until the response retires it.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N; i++) begin
      eligible[i] = req_valid_i[i] & ~rt_valid[req_id_i[i]];
    end
  end

  assign slot_free = ~mem_req_valid_o | mem_req_ready_i;
  assign arb_req   = eligible & {N{slot_free}};
  assign grant     = |gnt;
  assign gnt_id    = req_id_i[gnt_idx];
  assign resp_fire = mem_resp_valid_i & mem_resp_ready_i;

  assign req_ready_o    = gnt;
  assign mem_resp_sel_o = rt_port[mem_resp_id_i];

  hpdcache_rrarb #(
    .N  (N),
    .PW (PW)
  ) i_rrarb (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .req     (arb_req),
    .en      (grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_req_valid_o <= 1'b0;
      mem_req_o       <= '0;
      mem_req_id_o    <= '0;
    end else if (grant) begin
      mem_req_valid_o <= 1'b1;
      mem_req_o       <= req_i[gnt_idx];
      mem_req_id_o    <= gnt_id;
    end else if (mem_req_ready_i) begin
      mem_req_valid_o <= 1'b0;
    end
  end

  // Clear and set never hit the same ID: a granted ID was not in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rt_valid <= '0;
      rt_port  <= '{default: '0};
    end else begin
      if (resp_fire) begin
        rt_valid[mem_resp_id_i] <= 1'b0;
      end
      if (grant) begin
        rt_valid[gnt_id] <= 1'b1;
        rt_port[gnt_id]  <= req_portid_t'(gnt_idx);
      end
    end
  end

  resp_known_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    resp_fire |-> rt_valid[mem_resp_id_i])
    else $error("response handshake on id %0d with no outstanding request", mem_resp_id_i);

endmodule
